// File: rtl/des_cipher_ser.sv
// ==================================================================================
// des_cipher_ser: DES ciphertext word FIFO with MSB-byte-first serializer (rev 1.0)
// ==================================================================================
`default_nettype none

module des_cipher_ser #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [63:0]              cipher,
   input  logic                     cipher_rdy,
   output logic [7:0]               dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic                     dout_last,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     ovf_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   logic          state;
   logic          state_nxt;
   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [63:0]   sh;
   logic [2:0]    bc;

   logic          xfer;
   logic          have_word;
   logic          full;
   logic          pop;
   logic          wr;
   logic          drop;

   assign xfer      = dout_valid & dout_ready;
   assign have_word = (level != '0);
   assign full      = (level == LW'(DEPTH));
   // Pop refills the serializer either from idle or on the final byte, so words stream gap-free.
   assign pop       = have_word & ((state == ST_EMPTY) | (xfer & (bc == 3'd7)));
   assign wr        = cipher_rdy & (~full | pop);
   assign drop      = cipher_rdy & ~wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: if (have_word) state_nxt = ST_SHIFT;
         ST_SHIFT: if (xfer && bc == 3'd7 && !have_word) state_nxt = ST_EMPTY;
         default:  state_nxt = ST_EMPTY;
      endcase
   end

   always_comb begin
      dout       = sh[63:56];
      dout_valid = (state == ST_SHIFT);
      dout_last  = (state == ST_SHIFT) && (bc == 3'd7);
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= cipher;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp       <= '0;
         rp       <= '0;
         level    <= '0;
         sh       <= '0;
         bc       <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr)  wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;

         if (wr && !pop)      level <= level + 1'b1;
         else if (pop && !wr) level <= level - 1'b1;

         if (pop) begin
            sh <= mem[rp];
            bc <= '0;
         end else if (xfer) begin
            sh <= {sh[55:0], 8'h00};
            bc <= bc + 1'b1;
         end

         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: doc/des_cipher_ser.md
# des_cipher_ser

Output stage placed directly downstream of the 16-round DES encryption pipeline. It captures every 64-bit ciphertext word qualified by the pipeline's one-cycle `cipher_rdy` strobe into a small word FIFO. It then serializes each word MSB-byte-first onto an 8-bit valid/ready stream. The pipeline has no backpressure, so the block absorbs bursts and flags any word it is forced to drop.

## Interface
- `DEPTH`, default 4: FIFO depth in 64-bit words; power of two, minimum 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cipher`  in  64  ciphertext word from the encryption pipeline; bit 63 is the first bit of the block.
- `cipher_rdy`  in  1  one-cycle strobe qualifying `cipher`; may be high on consecutive cycles.
- `dout`  out  8  current output byte.
- `dout_valid`  out  1  `dout` holds a valid byte.
- `dout_ready`  in  1  sink accepts the byte; a transfer occurs when `dout_valid & dout_ready`.
- `dout_last`  out  1  high together with `dout_valid` on byte 7 (the last byte) of a word.
- `level`  out  $clog2(DEPTH)+1  number of words held in the FIFO; excludes the word being serialized.
- `overflow`  out  1  sticky flag: at least one word has been dropped.
- `ovf_clr`  in  1  synchronous clear of `overflow`.

## Operation
- **FIFO write:**
  - A write occurs when `cipher_rdy=1` and either `level<DEPTH`, or a pop happens in the same cycle.
  - Otherwise the word is discarded and `overflow` is set to 1 on that edge.
  - The write pointer wraps modulo DEPTH.
- **Serializer:** a 64-bit shift register `sh`, a 3-bit byte counter `bc`, and a `loaded` flag.
  - State EMPTY (`loaded=0`): if `level>0`, pop the FIFO head into `sh`, set `bc=0`, and go to SHIFT.
  - State SHIFT (`loaded=1`): `dout=sh[63:56]`, `dout_valid=1`, `dout_last=(bc==7)`.
  - On a transfer with `bc<7`: `sh<=sh<<8`, `bc<=bc+1`.
  - On a transfer with `bc==7` and `level>0`: pop and load the next word in the same edge, `bc=0`, stay in SHIFT. Words stream with no bubble.
  - On a transfer with `bc==7` and `level==0`: go to EMPTY and `dout_valid` drops on the next cycle.
  - With no transfer, `dout`, `dout_valid`, `dout_last` and `bc` hold. The sink may stall indefinitely.
- **Level:** `level` increments on write only, decrements on pop only, and is unchanged when both happen in the same cycle.
- **Overflow flag:**
  - `ovf_clr=1` clears `overflow`.
  - If a drop and `ovf_clr` occur in the same cycle, the set wins and `overflow` is 1.
- **Reset:**
  - Reset values: `dout=0`, `dout_valid=0`, `dout_last=0`, `level=0`, `overflow=0`.
  - Pointers, `bc` and `loaded` are 0.
  - A reset asserted mid-word discards the partial word and all FIFO contents immediately, without waiting for a clock edge.
- The block never reorders words. Bytes leave in order 63:56, 55:48, …, 7:0.

## Timing
- Empty block with `cipher_rdy` at cycle N: the word is written at the end of N, popped at the end of N+1, and `dout_valid=1` with byte 0 in cycle N+2.
- Sink with `dout_ready` held high: one byte per cycle, 8 cycles per word.
- Sustained input faster than 1 word per 8 cycles fills the FIFO. The drop point is therefore deterministic from the strobe pattern.
- `level` and `overflow` are registered and reflect the edge at the end of the previous cycle.
- `dout_valid` never drops without a completed last-byte transfer, except on reset.

## Test plan
- **Single word:** reset, then `cipher=64'h85E813540F0AB405` with a strobe at cycle 5 and `dout_ready=1`.
  - Bytes 85,E8,13,54,0F,0A,B4,05 appear in cycles 7–14.
  - `dout_last` is high only in cycle 14.
  - `level` is 1 in cycle 6 and 0 from cycle 7.
- **Back-to-back strobes:** 3 strobes on consecutive cycles with words A, B, C and `dout_ready=1`.
  - 24 contiguous valid bytes in order A, B, C with no bubble between words.
  - `overflow` stays 0.
- **Overflow:** DEPTH=4, `dout_ready=0`, 6 strobes with words W0..W5.
  - W0 is loaded into the serializer and W1..W4 fill the FIFO (`level=4`).
  - W5 is dropped and `overflow=1`.
  - After releasing `dout_ready`, exactly W0..W4 are output.
  - `ovf_clr` then returns `overflow` to 0.
- **Full with simultaneous pop:** FIFO full and `cipher_rdy` coincides with the last-byte transfer.
  - The word is accepted and `level` stays at DEPTH.
  - `overflow` stays 0.
- **Stalls:** toggle `dout_ready` pseudo-randomly with 50% duty over 20 words.
  - The output byte stream equals the concatenated input words.
  - `dout` is stable whenever `dout_valid=1` and `dout_ready=0`.
- **Reset mid-word:** assert `rst` after byte 3 of a word with 2 words queued.
  - `dout_valid`, `level` and `overflow` are immediately 0.
  - After release, no stale bytes are output and a new word serializes correctly.
